// File: rtl/hazard_fwd_pkg.sv
// Shared select encodings and shadow-stage records for the hazard/forwarding controller.
package hazard_fwd_pkg;

   localparam logic [1:0] FWD_REG = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_ALU = 2'b10;

   localparam int RA_W = 5;

   typedef struct packed {
      logic            valid;
      logic [RA_W-1:0] rd;
      logic            rw;
      logic            mr;
   } ex_stage_t;

   // Only the fields the forwarding compare needs survive past EX.
   typedef struct packed {
      logic            valid;
      logic [RA_W-1:0] rd;
      logic            rw;
   } mem_stage_t;

endpackage

// File: rtl/hazard_fwd_ctrl_fwd_src_sel.sv
// Per-operand forwarding source priority: younger EX ALU result beats older MEM writeback.
module fwd_src_sel
   import hazard_fwd_pkg::*;
(
   input  logic [RA_W-1:0] rs,
   input  logic            used,
   input  ex_stage_t       ex,
   input  mem_stage_t      mem,
   output logic [1:0]      sel
);

   // Loads in EX never forward here; the load-use stall covers them.
   always_comb begin
      sel = FWD_REG;
      if (used && rs != '0) begin
         if (ex.valid && ex.rw && !ex.mr && ex.rd == rs)
            sel = FWD_ALU;
         else if (mem.valid && mem.rw && mem.rd == rs)
            sel = FWD_WB;
      end
   end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Hazard and forwarding controller for the 5-stage RV32 pipeline: shadow pipe,
// registered forwarding selects, load-use stall, branch flush and event counters.
module hazard_fwd_ctrl
   import hazard_fwd_pkg::*;
#(
   parameter int REGADDR_W = RA_W,
   parameter int CNT_W     = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 pipe_hold,
   input  logic                 id_valid,
   input  logic [REGADDR_W-1:0] id_rs1,
   input  logic [REGADDR_W-1:0] id_rs2,
   input  logic                 id_uses_rs1,
   input  logic                 id_uses_rs2,
   input  logic [REGADDR_W-1:0] id_rd,
   input  logic                 id_regwrite,
   input  logic                 id_memread,
   input  logic                 ex_branch_taken,
   output logic [1:0]           fwd_a_sel,
   output logic [1:0]           fwd_b_sel,
   output logic                 pc_stall,
   output logic                 ifid_stall,
   output logic                 ifid_flush,
   output logic                 idex_bubble,
   output logic [CNT_W-1:0]     stall_cnt,
   output logic [CNT_W-1:0]     flush_cnt
);

   ex_stage_t  ex_q;
   mem_stage_t mem_q;
   logic       act;
   logic       lu;
   logic       fl;
   logic [1:0] sel_a;
   logic [1:0] sel_b;

   assign act = !rst && !pipe_hold;

   assign lu = id_valid && ex_q.valid && ex_q.mr && (ex_q.rd != '0) &&
               ((id_uses_rs1 && id_rs1 == ex_q.rd) ||
                (id_uses_rs2 && id_rs2 == ex_q.rd));

   assign fl = ex_branch_taken && ex_q.valid;

   // Flush wins over load-use: the stalled ID instruction is wrong-path.
   always_comb begin
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      pc_stall    = 1'b0;
      ifid_stall  = 1'b0;
      if (act) begin
         ifid_flush  = fl;
         idex_bubble = fl || lu;
         pc_stall    = lu && !fl;
         ifid_stall  = lu && !fl;
      end
   end

   fwd_src_sel u_sel_a (
      .rs   (id_rs1),
      .used (id_uses_rs1),
      .ex   (ex_q),
      .mem  (mem_q),
      .sel  (sel_a)
   );

   fwd_src_sel u_sel_b (
      .rs   (id_rs2),
      .used (id_uses_rs2),
      .ex   (ex_q),
      .mem  (mem_q),
      .sel  (sel_b)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_q      <= '0;
         mem_q     <= '0;
         fwd_a_sel <= FWD_REG;
         fwd_b_sel <= FWD_REG;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else if (!pipe_hold) begin
         ex_q.valid <= id_valid && !idex_bubble;
         ex_q.rd    <= id_rd;
         ex_q.rw    <= id_regwrite;
         ex_q.mr    <= id_memread;
         mem_q.valid <= ex_q.valid;
         mem_q.rd    <= ex_q.rd;
         mem_q.rw    <= ex_q.rw;
         fwd_a_sel <= idex_bubble ? FWD_REG : sel_a;
         fwd_b_sel <= idex_bubble ? FWD_REG : sel_b;
         if (pc_stall && stall_cnt != '1)
            stall_cnt <= stall_cnt + CNT_W'(1);
         if (ifid_flush && flush_cnt != '1)
            flush_cnt <= flush_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Directed bench for hazard_fwd_ctrl: comb controls checked in-cycle, selects via an expectation queue.
module tb_hazard_fwd_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        pipe_hold;
   logic        id_valid;
   logic [4:0]  id_rs1, id_rs2, id_rd;
   logic        id_uses_rs1, id_uses_rs2;
   logic        id_regwrite, id_memread;
   logic        ex_branch_taken;
   logic [1:0]  fwd_a_sel, fwd_b_sel;
   logic        pc_stall, ifid_stall, ifid_flush, idex_bubble;
   logic [31:0] stall_cnt, flush_cnt;

   int n_assert = 0;
   int n_fail   = 0;
   logic [3:0] exp_q[$];

   always #5 clk = ~clk;

   hazard_fwd_ctrl #(.REGADDR_W(5), .CNT_W(32)) dut (
      .clk             (clk),
      .rst             (rst),
      .pipe_hold       (pipe_hold),
      .id_valid        (id_valid),
      .id_rs1          (id_rs1),
      .id_rs2          (id_rs2),
      .id_uses_rs1     (id_uses_rs1),
      .id_uses_rs2     (id_uses_rs2),
      .id_rd           (id_rd),
      .id_regwrite     (id_regwrite),
      .id_memread      (id_memread),
      .ex_branch_taken (ex_branch_taken),
      .fwd_a_sel       (fwd_a_sel),
      .fwd_b_sel       (fwd_b_sel),
      .pc_stall        (pc_stall),
      .ifid_stall      (ifid_stall),
      .ifid_flush      (ifid_flush),
      .idex_bubble     (idex_bubble),
      .stall_cnt       (stall_cnt),
      .flush_cnt       (flush_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic drive(input logic hold, input logic v, input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                        input logic rw, input logic mr, input logic br);
      pipe_hold       = hold;
      id_valid        = v;
      id_rs1          = rs1;
      id_uses_rs1     = u1;
      id_rs2          = rs2;
      id_uses_rs2     = u2;
      id_rd           = rd;
      id_regwrite     = rw;
      id_memread      = mr;
      ex_branch_taken = br;
   endtask

   // One pipeline cycle: drive ID, check same-cycle controls, queue the selects the edge should load.
   task automatic step(input string tag, input logic hold, input logic v,
                       input logic [4:0] rs1, input logic u1, input logic [4:0] rs2, input logic u2,
                       input logic [4:0] rd, input logic rw, input logic mr, input logic br,
                       input logic e_stall, input logic e_flush, input logic e_bub,
                       input logic [1:0] e_a, input logic [1:0] e_b);
      logic [3:0] e;
      @(negedge clk);
      drive(hold, v, rs1, u1, rs2, u2, rd, rw, mr, br);
      #1;
      chk({tag, ".pc_stall"},    {31'd0, pc_stall},    {31'd0, e_stall});
      chk({tag, ".ifid_stall"},  {31'd0, ifid_stall},  {31'd0, e_stall});
      chk({tag, ".ifid_flush"},  {31'd0, ifid_flush},  {31'd0, e_flush});
      chk({tag, ".idex_bubble"}, {31'd0, idex_bubble}, {31'd0, e_bub});
      exp_q.push_back({e_a, e_b});
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         chk({tag, ".queue_empty"}, 32'd0, 32'd1);
      end else begin
         e = exp_q.pop_front();
         chk({tag, ".fwd_a_sel"}, {30'd0, fwd_a_sel}, {30'd0, e[3:2]});
         chk({tag, ".fwd_b_sel"}, {30'd0, fwd_b_sel}, {30'd0, e[1:0]});
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1;
      chk("rst.fwd_a_sel", {30'd0, fwd_a_sel}, 32'd0);
      chk("rst.fwd_b_sel", {30'd0, fwd_b_sel}, 32'd0);
      chk("rst.stall_cnt", stall_cnt, 32'd0);
      chk("rst.flush_cnt", flush_cnt, 32'd0);
      chk("rst.ctrl", {28'd0, pc_stall, ifid_stall, ifid_flush, idex_bubble}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      //    tag          hold v  rs1 u1 rs2 u2 rd  rw mr br  st fl bub a  b
      step("alu_add",    0,  1, 1,  1, 2,  1, 5,  1, 0, 0,  0, 0, 0,  0, 0);
      step("alu_sub",    0,  1, 5,  1, 7,  1, 6,  1, 0, 0,  0, 0, 0,  2, 0);
      step("nop1",       0,  0, 0,  0, 0,  0, 0,  0, 0, 0,  0, 0, 0,  0, 0);
      step("gap_add",    0,  1, 1,  1, 2,  1, 5,  1, 0, 0,  0, 0, 0,  0, 0);
      step("nop2",       0,  0, 0,  0, 0,  0, 0,  0, 0, 0,  0, 0, 0,  0, 0);
      step("gap_or",     0,  1, 5,  1, 5,  1, 8,  1, 0, 0,  0, 0, 0,  1, 1);
      step("lu_lw",      0,  1, 1,  1, 0,  0, 5,  1, 1, 0,  0, 0, 0,  0, 0);
      step("lu_stall",   0,  1, 5,  1, 1,  1, 6,  1, 0, 0,  1, 0, 1,  0, 0);
      step("lu_retry",   0,  1, 5,  1, 1,  1, 6,  1, 0, 0,  0, 0, 0,  1, 0);
      chk("lu.stall_cnt", stall_cnt, 32'd1);
      chk("lu.flush_cnt", flush_cnt, 32'd0);

      step("dbl_add1",   0,  1, 1,  1, 2,  1, 5,  1, 0, 0,  0, 0, 0,  0, 0);
      step("dbl_add2",   0,  1, 3,  1, 4,  1, 5,  1, 0, 0,  0, 0, 0,  0, 0);
      step("dbl_use",    0,  1, 5,  1, 0,  1, 9,  1, 0, 0,  0, 0, 0,  2, 0);

      step("br_lw",      0,  1, 2,  1, 0,  0, 7,  1, 1, 0,  0, 0, 0,  0, 0);
      step("br_flush",   0,  1, 7,  1, 1,  1, 10, 1, 0, 1,  0, 1, 1,  0, 0);
      step("br_after",   0,  1, 1,  1, 2,  1, 11, 1, 0, 0,  0, 0, 0,  0, 0);
      chk("br.stall_cnt", stall_cnt, 32'd1);
      chk("br.flush_cnt", flush_cnt, 32'd1);

      step("pre_hold",   0,  1, 11, 1, 11, 1, 12, 1, 0, 0,  0, 0, 0,  2, 2);
      for (int i = 0; i < 3; i++)
         step("hold",    1,  1, 12, 1, 11, 1, 20, 1, 1, 1,  0, 0, 0,  2, 2);
      chk("hold.stall_cnt", stall_cnt, 32'd1);
      chk("hold.flush_cnt", flush_cnt, 32'd1);
      step("post_hold",  0,  1, 12, 1, 1,  1, 13, 1, 0, 0,  0, 0, 0,  2, 0);

      step("rst_lw",     0,  1, 1,  1, 0,  0, 14, 1, 1, 0,  0, 0, 0,  0, 0);
      @(negedge clk);
      drive(0, 1, 14, 1, 0, 1, 15, 1, 0, 0);
      #1;
      chk("rst_stall.pc_stall", {31'd0, pc_stall}, 32'd1);
      rst = 1'b1;
      #1;
      chk("rst_stall.ctrl_forced", {28'd0, pc_stall, ifid_stall, ifid_flush, idex_bubble}, 32'd0);
      @(posedge clk);
      #1;
      chk("rst_stall.stall_cnt", stall_cnt, 32'd0);
      chk("rst_stall.flush_cnt", flush_cnt, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      step("post_rst",   0,  1, 14, 1, 0,  1, 15, 1, 0, 0,  0, 0, 0,  0, 0);
      chk("post_rst.stall_cnt", stall_cnt, 32'd0);
      chk("post_rst.flush_cnt", flush_cnt, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/hazard_fwd_ctrl.md
# hazard_fwd_ctrl

Hazard and forwarding controller for the 5-stage RV32 pipeline. It keeps a shadow copy of destination-register and control bits for the EX, MEM and WB stages, and drives the forwarding selects of both EX-stage operand muxes. It also detects load-use hazards, inserting one bubble, and squashes wrong-path instructions on a taken branch. It sits beside the ID/EX pipeline register and feeds the operand A/B forwarding muxes, the PC and the IF/ID register.

## Interface
Parameters:
- REGADDR_W, 5, register address width
- CNT_W, 32, performance counter width

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous, active-high reset
- pipe_hold  in  1  global freeze (memory wait); all internal state holds
- id_valid  in  1  ID-stage instruction is real
- id_rs1, id_rs2  in  REGADDR_W  ID-stage source registers
- id_uses_rs1, id_uses_rs2  in  1  operand actually read
- id_rd  in  REGADDR_W  ID-stage destination
- id_regwrite  in  1  ID instruction writes rd
- id_memread  in  1  ID instruction is a load
- ex_branch_taken  in  1  EX-stage branch/jump redirects the PC this cycle
- fwd_a_sel, fwd_b_sel  out  2  EX operand select: 00 regfile/PC/imm, 01 WB data, 10 ALU result (MEM stage)
- pc_stall  out  1  hold PC
- ifid_stall  out  1  hold IF/ID register
- ifid_flush  out  1  zero IF/ID register
- idex_bubble  out  1  load NOP into ID/EX
- stall_cnt, flush_cnt  out  CNT_W  saturating event counters

## Operation
- Shadow pipe: ex_{valid,rs1,rs2,rd,rw,mr} → mem_{valid,rd,rw,mr} → wb_{valid,rd,rw}. Advances on every clock when pipe_hold=0.
- ex_valid loads id_valid & !bubble, where bubble = idex_bubble.
- Load-use: lu = ex_valid & ex_mr & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)) & id_valid.
- Flush: fl = ex_branch_taken & ex_valid.
- Outputs (combinational, forced 0 while rst=1 or pipe_hold=1):
  - ifid_flush = fl
  - idex_bubble = fl | lu
  - pc_stall = ifid_stall = lu & !fl
- Priority: the flush beats load-use. The stalled ID instruction is wrong-path anyway.
- Next-cycle select per operand r, computed from ID-stage values and registered:
  - r==0 or operand unused → 00
  - ex_valid & ex_rw & !ex_mr & ex_rd==r → 10
  - else mem_valid & mem_rw & mem_rd==r → 01
  - else 00
- A matching ex load never produces a select, because lu has already stalled it. The MEM-stage match beats the WB match (youngest wins).
- On a bubble, the registered selects load 00.
- Counters:
  - stall_cnt increments on cycles with pc_stall=1.
  - flush_cnt increments on cycles with ifid_flush=1.
  - Both saturate at all-ones.

## Timing
- Reset: all shadow valids 0, fwd_a_sel = fwd_b_sel = 00, counters 0, all control outputs 0.
- Selects have one-cycle latency. They are registered on the same edge that moves the instruction from ID to EX, so they are valid for the whole EX cycle. There is no comb path from inputs to the selects.
- Stall and flush outputs respond in the same cycle.
- A load-use stall lasts exactly one cycle. The next cycle the load is in MEM, ex_valid=0, and the consumer re-evaluates and gets select 01 on entering EX.
- pipe_hold=1: shadow pipe, selects and counters frozen; control outputs 0.
- Reset asserted mid-stall or mid-flush clears everything on the next edge. No residual stall.
- x0 is never forwarded and never stalls.

## Structure
- Package hazard_fwd_pkg holds:
  - FWD_REG = 2'b00, FWD_WB = 2'b01, FWD_ALU = 2'b10
  - the shadow-stage struct types
- Sub-module fwd_src_sel: the combinational per-operand priority compare. It is instantiated twice, for operands A and B.

## Test plan
- Back-to-back ALU: add x5 then sub x6,x5,x7 → fwd_a_sel=10 in the sub's EX cycle; no stall.
- One-instruction gap: add x5; nop; or x8,x5,x5 → fwd_a_sel = fwd_b_sel = 01.
- Load-use: lw x5 then add x6,x5,x1 → pc_stall/ifid_stall/idex_bubble=1 for exactly one cycle; add then sees fwd_a_sel=01; stall_cnt=1.
- Double match: add x5 → add x5 → add x9,x5,x0 → fwd_a_sel=10 (MEM beats WB), fwd_b_sel=00 (x0).
- Branch taken in EX while ID holds a load-use consumer → ifid_flush=1, idex_bubble=1, pc_stall=0; flush_cnt=1, stall_cnt unchanged.
- pipe_hold=1 for 3 cycles mid-stream, then reset during a stall → state frozen during the hold; after reset all outputs are 0 and both counters are 0.
